// File: rtl/alsu_driver_if.sv
// ============================================================================
// Module   : alsu_driver_if
// Purpose  : Command and response handshake bundle between a host sequencer
//            and the ALSU command driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alsu_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_data;
    logic [15:0] rsp_leds;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_leds, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_leds, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/alsu_driver.sv
// ============================================================================
// Module   : alsu_driver
// Purpose  : Accepts one ALSU command, drives the ALSU inputs, waits out the
//            ALSU pipeline latency and returns the captured result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alsu_driver #(
    parameter int LATENCY = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alsu_driver_if.slave     bus,
    output logic [2:0]       a_o,
    output logic [2:0]       b_o,
    output logic [2:0]       opcode_o,
    output logic             cin_o,
    output logic             serial_in_o,
    output logic             red_op_a_o,
    output logic             red_op_b_o,
    output logic             bypass_a_o,
    output logic             bypass_b_o,
    output logic             direction_o,
    input  wire logic [5:0]  alsu_out_i,
    input  wire logic [15:0] alsu_leds_i
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        drv_q, drv_d;
    logic [5:0]         data_q, data_d;
    logic [15:0]        leds_q, leds_d;
    logic               err_q, err_d;

    logic [2:0]         w_cmd_op;
    logic               w_cmd_red;
    logic               w_cmd_byp;
    logic               w_cmd_err;

    // Mirrors the ALSU's own invalid-operation rule so the response can flag it.
    assign w_cmd_op  = bus.cmd_data[9:7];
    assign w_cmd_red = bus.cmd_data[4] | bus.cmd_data[3];
    assign w_cmd_byp = bus.cmd_data[2] | bus.cmd_data[1];
    assign w_cmd_err = !w_cmd_byp &&
                       ((w_cmd_op[2:1] == 2'b11) ||
                        ((w_cmd_op >= 3'd2) && (w_cmd_op <= 3'd5) && w_cmd_red));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drv_q   <= '0;
            data_q  <= '0;
            leds_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drv_q   <= drv_d;
            data_q  <= data_d;
            leds_q  <= leds_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drv_d   = drv_q;
        data_d  = data_q;
        leds_d  = leds_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    drv_d   = bus.cmd_data;
                    err_d   = w_cmd_err;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Capture one edge after the counter empties: out is stable then.
                if (cnt_q == '0) begin
                    data_d  = alsu_out_i;
                    leds_d  = alsu_leds_i;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_leds  = leds_q;
    assign bus.rsp_err   = err_q;

    assign a_o         = drv_q[15:13];
    assign b_o         = drv_q[12:10];
    assign opcode_o    = drv_q[9:7];
    assign cin_o       = drv_q[6];
    assign serial_in_o = drv_q[5];
    assign red_op_a_o  = drv_q[4];
    assign red_op_b_o  = drv_q[3];
    assign bypass_a_o  = drv_q[2];
    assign bypass_b_o  = drv_q[1];
    assign direction_o = drv_q[0];

endmodule

`default_nettype wire

// File: tb/tb_alsu_driver.sv
// ============================================================================
// Module   : tb_alsu_driver
// Purpose  : Directed self-checking bench for alsu_driver with an ALSU model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alsu_driver;

    logic        clk;
    logic        rst_n;
    logic [2:0]  a_w, b_w, op_w;
    logic        cin_w, sin_w, ra_w, rb_w, ba_w, bb_w, dir_w;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    alsu_driver_if u_if ();

    alsu_driver #(.LATENCY(2)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_if),
        .a_o         (a_w),
        .b_o         (b_w),
        .opcode_o    (op_w),
        .cin_o       (cin_w),
        .serial_in_o (sin_w),
        .red_op_a_o  (ra_w),
        .red_op_b_o  (rb_w),
        .bypass_a_o  (ba_w),
        .bypass_b_o  (bb_w),
        .direction_o (dir_w),
        .alsu_out_i  (alsu_out),
        .alsu_leds_i (alsu_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALSU model: registered inputs, registered out/leds (FULL_ADDER on, unsigned).
    logic [2:0] m_a, m_b, m_op;
    logic       m_cin, m_sin, m_ra, m_rb, m_ba, m_bb, m_dir;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {m_a, m_b, m_op} <= '0;
            {m_cin, m_sin, m_ra, m_rb, m_ba, m_bb, m_dir} <= '0;
            alsu_out  <= '0;
            alsu_leds <= '0;
        end else begin
            {m_a, m_b, m_op} <= {a_w, b_w, op_w};
            {m_cin, m_sin, m_ra, m_rb, m_ba, m_bb, m_dir} <=
                {cin_w, sin_w, ra_w, rb_w, ba_w, bb_w, dir_w};
            if (m_ba) begin
                alsu_out <= {3'b0, m_a}; alsu_leds <= '0;
            end else if (m_bb) begin
                alsu_out <= {3'b0, m_b}; alsu_leds <= '0;
            end else if (m_op[2:1] == 2'b11 ||
                         (m_op >= 3'd2 && m_op <= 3'd5 && (m_ra || m_rb))) begin
                alsu_out <= '0; alsu_leds <= ~alsu_leds;
            end else begin
                alsu_leds <= '0;
                case (m_op)
                    3'd0: alsu_out <= m_ra ? {5'b0, &m_a} : m_rb ? {5'b0, &m_b} : {3'b0, m_a & m_b};
                    3'd1: alsu_out <= m_ra ? {5'b0, ^m_a} : m_rb ? {5'b0, ^m_b} : {3'b0, m_a ^ m_b};
                    3'd2: alsu_out <= 6'(m_a) + 6'(m_b) + 6'(m_cin);
                    3'd3: alsu_out <= 6'(m_a) * 6'(m_b);
                    3'd4: alsu_out <= m_dir ? {alsu_out[4:0], m_sin} : {m_sin, alsu_out[5:1]};
                    default: alsu_out <= m_dir ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
                endcase
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] op, input logic [6:0] ctl);
        return {a, b, op, ctl};
    endfunction

    // ctl bits: {cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}
    task automatic send(input logic [15:0] d);
        int n = 0;
        u_if.cmd_data  = d;
        u_if.cmd_valid = 1'b1;
        while (!u_if.cmd_ready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 30) check_eq("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        acc_cyc        = cyc;
        u_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int n = 0;
        while (!u_if.rsp_valid && n < 30) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 30) check_eq("rsp_timeout", 0, 1);
        lat = cyc - acc_cyc;
    endtask

    task automatic finish_rsp();
        u_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        u_if.rsp_ready = 1'b0;
        check_eq("idle_after_hs", u_if.cmd_ready, 1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc1;
        rst_n          = 1'b0;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_data  = '0;
        u_if.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check_eq("rst_cmd_ready", u_if.cmd_ready, 1);
        check_eq("rst_rsp_valid", u_if.rsp_valid, 0);
        check_eq("rst_rsp_data",  u_if.rsp_data, 0);
        check_eq("rst_rsp_err",   u_if.rsp_err, 0);
        check_eq("rst_drive",     {a_w, b_w, op_w, cin_w, ba_w, dir_w}, 0);

        // ADD 3+5+1
        send(mk(3'd3, 3'd5, 3'b010, 7'b1000000));
        check_eq("add_drive_a", a_w, 3);
        wait_rsp(lat);
        check_eq("add_latency", lat, 3);
        check_eq("add_data", u_if.rsp_data, 9);
        check_eq("add_err",  u_if.rsp_err, 0);
        check_eq("add_leds", u_if.rsp_leds, 0);
        finish_rsp();

        // AND then XOR back-to-back with rsp_ready held
        u_if.rsp_ready = 1'b1;
        send(mk(3'd6, 3'd3, 3'b000, 7'b0));
        acc1 = acc_cyc;
        wait_rsp(lat);
        check_eq("and_data", u_if.rsp_data, 2);
        send(mk(3'd6, 3'd3, 3'b001, 7'b0));
        check_eq("b2b_period", acc_cyc - acc1, 5);
        wait_rsp(lat);
        check_eq("xor_data", u_if.rsp_data, 5);
        @(posedge clk); #1;
        u_if.rsp_ready = 1'b0;
        check_eq("b2b_idle", u_if.cmd_ready, 1);

        // Invalid opcode, then reduction with arithmetic opcode
        send(mk(3'd5, 3'd2, 3'b110, 7'b0));
        wait_rsp(lat);
        check_eq("inv_data", u_if.rsp_data, 0);
        check_eq("inv_err",  u_if.rsp_err, 1);
        check_eq("inv_leds", u_if.rsp_leds, 16'hFFFF);
        finish_rsp();
        send(mk(3'd5, 3'd2, 3'b011, 7'b0010000));
        wait_rsp(lat);
        check_eq("red_inv_data", u_if.rsp_data, 0);
        check_eq("red_inv_err",  u_if.rsp_err, 1);
        finish_rsp();

        // Bypass A then rotate left by one
        send(mk(3'd1, 3'd0, 3'b000, 7'b0000100));
        wait_rsp(lat);
        check_eq("byp_data", u_if.rsp_data, 6'b000001);
        check_eq("byp_err",  u_if.rsp_err, 0);
        finish_rsp();
        send(mk(3'd1, 3'd0, 3'b101, 7'b0000001));
        wait_rsp(lat);
        check_eq("rot_data", u_if.rsp_data, 6'b000010);
        check_eq("rot_err",  u_if.rsp_err, 0);
        check_eq("rot_drive_op", op_w, 3'b101);
        finish_rsp();
        check_eq("rot_hold_op", op_w, 3'b101);

        // Backpressure for 10 cycles with a stray command pulse
        send(mk(3'd2, 3'd2, 3'b010, 7'b0));
        wait_rsp(lat);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                u_if.cmd_data  = mk(3'd7, 3'd7, 3'b000, 7'b0);
                u_if.cmd_valid = 1'b1;
            end
            @(posedge clk); #1;
            u_if.cmd_valid = 1'b0;
            check_eq("bp_valid", u_if.rsp_valid, 1);
            check_eq("bp_data",  u_if.rsp_data, 4);
            check_eq("bp_ready", u_if.cmd_ready, 0);
        end
        check_eq("bp_no_accept", a_w, 2);
        finish_rsp();

        // Reset while waiting on the ALSU
        send(mk(3'd3, 3'd3, 3'b010, 7'b0));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_drive",     {a_w, b_w, op_w}, 0);
        check_eq("arst_rsp_valid", u_if.rsp_valid, 0);
        check_eq("arst_rsp_data",  u_if.rsp_data, 0);
        check_eq("arst_cmd_ready", u_if.cmd_ready, 1);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("arst_no_rsp", u_if.rsp_valid, 0);
        end
        send(mk(3'd1, 3'd1, 3'b010, 7'b0));
        wait_rsp(lat);
        check_eq("post_rst_latency", lat, 3);
        check_eq("post_rst_data", u_if.rsp_data, 2);
        finish_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
